// File: rtl/uiip_hdr_csum_engine_pkg.sv
// Shared types and constants for the IPv4 header checksum engine and the transmit header builder.
package uiip_hdr_csum_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACCUM = 3'd1,
      ST_FOLD1 = 3'd2,
      ST_FOLD2 = 3'd3,
      ST_SKIP  = 3'd4
   } state_e;

   localparam logic [3:0]  IPV4_VERSION  = 4'd4;
   localparam logic [3:0]  MIN_IHL       = 4'd5;
   localparam int unsigned CSUM_BYTE_OFS = 10;
   localparam logic [15:0] CSUM_GOOD     = 16'hFFFF;

   // 30 words of 16'hFFFF fit in 21 bits, so no carry is lost while accumulating
   localparam int unsigned ACC_W  = 21;
   localparam int unsigned FOLD_W = 17;
   localparam int unsigned CNT_W  = 6;

   // Byte 0 of an IPv4 header carries version (high nibble) and IHL (low nibble)
   function automatic logic hdr_bad(input logic [7:0] byte0);
      return (byte0[7:4] != IPV4_VERSION) || (byte0[3:0] < MIN_IHL);
   endfunction

endpackage

// File: rtl/uiip_csum_fold.sv
// One end-around-carry fold step: 21-bit accumulator down to a 17-bit partial sum.
module uiip_csum_fold
   import uiip_hdr_csum_engine_pkg::*;
(
   input  logic [ACC_W-1:0]  I_sum,
   output logic [FOLD_W-1:0] O_fold_c
);

   // Two folds bring any 21-bit sum to 16 bits; the second fold never carries
   always_comb begin
      O_fold_c = FOLD_W'(I_sum[15:0]) + FOLD_W'(I_sum[ACC_W-1:16]);
   end

endmodule

// File: rtl/uiip_hdr_csum_engine.sv
// IPv4 header checksum engine: checks or generates the header checksum over an
// 8/16/32-bit big-endian header stream, honouring IHL, one result strobe per header.
module uiip_hdr_csum_engine
   import uiip_hdr_csum_engine_pkg::*;
#(
   parameter int unsigned DATA_W = 8
)(
   input  logic              I_clk,
   input  logic              I_reset,
   input  logic              I_ip_sof,
   input  logic              I_ip_rdata_valid,
   input  logic [DATA_W-1:0] I_ip_rdata,
   input  logic              I_gen_mode,
   output logic              O_done,
   output logic              O_csum_ok,
   output logic              O_hdr_error,
   output logic [15:0]       O_csum_value,
   output logic              O_checksum_rerror
);

   localparam int unsigned BYTES      = DATA_W / 8;
   localparam int unsigned BEAT_SHIFT = $clog2(BYTES);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [3:0]       ihl_q, ihl_d;
   logic             bad_q, bad_d;
   logic             done_q, done_d;
   logic             ok_q, ok_d;
   logic             herr_q, herr_d;
   logic [15:0]      val_q, val_d;
   logic             rerr_q, rerr_d;

   logic             take_sof_c;
   logic             mask_gen_c;
   logic [CNT_W-1:0] beat_idx_c;
   logic [CNT_W-1:0] last_beat_c;
   logic [ACC_W-1:0] beat_add_c;
   logic [FOLD_W-1:0] fold_c;
   logic [15:0]      folded_c;
   logic             ok_c;
   logic [7:0]       byte0_c;

   // A valid SOF starts a new header everywhere except while folding
   always_comb begin
      take_sof_c = I_ip_rdata_valid && I_ip_sof &&
                   (state_q != ST_FOLD1) && (state_q != ST_FOLD2);
      mask_gen_c = take_sof_c ? I_gen_mode : mode_q;
      beat_idx_c = take_sof_c ? '0 : cnt_q;
      byte0_c    = I_ip_rdata[DATA_W-1 -: 8];
   end

   // Index of the final header beat: IHL*4 bytes spread over BYTES-wide beats
   always_comb begin
      last_beat_c = CNT_W'({ihl_q, 2'b00} >> BEAT_SHIFT) - CNT_W'(1);
   end

   // Per-beat contribution to the ones-complement sum, checksum field masked in generate mode
   generate
      if (DATA_W == 8) begin : g_bytes
         always_comb begin
            beat_add_c = '0;
            if (!(mask_gen_c && ((beat_idx_c == CNT_W'(CSUM_BYTE_OFS)) ||
                                 (beat_idx_c == CNT_W'(CSUM_BYTE_OFS + 1)))))
               beat_add_c = beat_idx_c[0] ? ACC_W'(I_ip_rdata) : ACC_W'({I_ip_rdata, 8'h00});
         end
      end else begin : g_words
         localparam int unsigned WORDS = BYTES / 2;
         logic [7:0] base_pos_c;
         always_comb begin
            beat_add_c = '0;
            base_pos_c = 8'(beat_idx_c) * 8'(BYTES);
            for (int unsigned w = 0; w < WORDS; w++) begin
               if (!(mask_gen_c && ((base_pos_c + 8'(2 * w)) == 8'(CSUM_BYTE_OFS))))
                  beat_add_c = beat_add_c + ACC_W'(I_ip_rdata[DATA_W-1-16*w -: 16]);
            end
         end
      end
   endgenerate

   uiip_csum_fold u_fold (
      .I_sum    (sum_q),
      .O_fold_c (fold_c)
   );

   // Final result terms from the twice-folded sum
   always_comb begin
      folded_c = fold_c[15:0];
      ok_c     = !bad_q && (mode_q || (folded_c == CSUM_GOOD));
   end

   // Next-state, accumulator and result register logic
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      ihl_d   = ihl_q;
      bad_d   = bad_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      herr_d  = herr_q;
      val_d   = val_q;
      rerr_d  = rerr_q;

      if (take_sof_c) begin
         mode_d  = I_gen_mode;
         ihl_d   = byte0_c[3:0];
         bad_d   = hdr_bad(byte0_c);
         sum_d   = beat_add_c;
         cnt_d   = CNT_W'(1);
         state_d = hdr_bad(byte0_c) ? ST_FOLD1 : ST_ACCUM;
      end else begin
         case (state_q)
            ST_IDLE, ST_SKIP: begin
               state_d = state_q;
            end
            ST_ACCUM: begin
               if (I_ip_rdata_valid) begin
                  sum_d = sum_q + beat_add_c;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == last_beat_c)
                     state_d = ST_FOLD1;
               end
            end
            ST_FOLD1: begin
               sum_d   = ACC_W'(fold_c);
               state_d = ST_FOLD2;
            end
            ST_FOLD2: begin
               done_d  = 1'b1;
               ok_d    = ok_c;
               herr_d  = bad_q;
               val_d   = mode_q ? ~folded_c : folded_c;
               rerr_d  = !ok_c || bad_q;
               cnt_d   = '0;
               state_d = ST_SKIP;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and result registers, cleared by the asynchronous reset
   always_ff @(posedge I_clk or posedge I_reset) begin
      if (I_reset) begin
         state_q <= ST_IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         ihl_q   <= '0;
         bad_q   <= 1'b0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         herr_q  <= 1'b0;
         val_q   <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         ihl_q   <= ihl_d;
         bad_q   <= bad_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         herr_q  <= herr_d;
         val_q   <= val_d;
         rerr_q  <= rerr_d;
      end
   end

   assign O_done            = done_q;
   assign O_csum_ok         = ok_q;
   assign O_hdr_error       = herr_q;
   assign O_csum_value      = val_q;
   assign O_checksum_rerror = rerr_q;

endmodule
